// File: rtl/wifi_tx_pkg.sv
// Shared transmitter definitions: code rates, generator polynomials, puncture tables.
package wifi_tx_pkg;

    localparam int unsigned K    = 7;
    localparam int unsigned SR_W = K - 1;
    localparam int unsigned PH_W = 2;

    localparam logic [K-1:0] G0 = 7'o133;
    localparam logic [K-1:0] G1 = 7'o171;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rate_e;

    typedef struct packed {
        logic a;
        logic b;
    } emit_t;

    // Number of input bits per puncture pattern; reserved rate falls back to 1/2.
    function automatic logic [PH_W-1:0] punct_period(input rate_e rate);
        logic [PH_W-1:0] period;
        case (rate)
            RATE_2_3: period = PH_W'(2);
            RATE_3_4: period = PH_W'(3);
            default:  period = PH_W'(1);
        endcase
        return period;
    endfunction

    // Which of A/B survive puncturing at a given phase.
    function automatic emit_t punct_mask(input rate_e rate, input logic [PH_W-1:0] phase);
        emit_t m;
        m = emit_t'(2'b11);
        case (rate)
            RATE_2_3: begin
                if (phase == PH_W'(1)) m.b = 1'b0;
            end
            RATE_3_4: begin
                if (phase == PH_W'(1))      m.b = 1'b0;
                else if (phase == PH_W'(2)) m.a = 1'b0;
            end
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/conv_encoder_core.sv
// K=7 shift register with G0/G1 parity taps; sr[SR_W-1] holds the most recent bit.
module conv_encoder_core
    import wifi_tx_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic enable,
    input  logic clear,
    input  logic data_bit,
    output logic code_a_c,
    output logic code_b_c
);

    logic [SR_W-1:0] sr_q;
    logic [K-1:0]    window_c;

    // Window MSB is the incoming bit, LSB the oldest, matching polynomial bit order.
    assign window_c = {data_bit, sr_q};
    assign code_a_c = ^(window_c & G0);
    assign code_b_c = ^(window_c & G1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sr_q <= '0;
        end else if (clear) begin
            sr_q <= '0;
        end else if (enable) begin
            sr_q <= {data_bit, sr_q[SR_W-1:1]};
        end
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 convolutional encoder with optional 2/3, 3/4 puncturing and a 2-bit output queue.
// Puncturing is built only when CONV_PUNCTURE_EN is defined; otherwise the encoder is fixed at rate 1/2.
module conv_encoder
    import wifi_tx_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [1:0] Rate,
    input  logic       InValid,
    input  logic       InBit,
    output logic       InReady,
    output logic       OutValid,
    output logic       OutBit,
    input  logic       OutReady
);

    localparam int unsigned CNT_W = 2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       bits_q, bits_d;
    logic             valid_q, valid_d;
    logic             accept_c, pop_c;
    logic             code_a_c, code_b_c;
    emit_t            emit_c;

    // Accept only when the queue will be empty after this cycle's pop.
    assign InReady  = !Start && ((cnt_q == CNT_W'(0)) || ((cnt_q == CNT_W'(1)) && OutReady));
    assign accept_c = InValid && InReady;
    assign pop_c    = valid_q && OutReady;
    assign OutValid = valid_q;
    assign OutBit   = bits_q[0];

    conv_encoder_core u_core (
        .Clock    (Clock),
        .Reset    (Reset),
        .enable   (accept_c),
        .clear    (Start),
        .data_bit (InBit),
        .code_a_c (code_a_c),
        .code_b_c (code_b_c)
    );

`ifdef CONV_PUNCTURE_EN
    rate_e           rate_q, rate_d;
    logic [PH_W-1:0] phase_q, phase_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rate_q  <= RATE_1_2;
            phase_q <= '0;
        end else begin
            rate_q  <= rate_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        rate_d  = rate_q;
        phase_d = phase_q;
        emit_c  = punct_mask(rate_q, phase_q);
        if (Start) begin
            rate_d  = rate_e'(Rate);
            phase_d = '0;
        end else if (accept_c) begin
            phase_d = ((phase_q + PH_W'(1)) == punct_period(rate_q)) ? '0 : phase_q + PH_W'(1);
        end
    end
`else
    logic unused_rate;
    assign unused_rate = ^Rate;

    always_comb begin
        emit_c = emit_t'(2'b11);
    end
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q   <= '0;
            bits_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            valid_q <= valid_d;
        end
    end

    // Queue update: pop the head, then either flush on Start or load the surviving code bits.
    always_comb begin
        cnt_d  = cnt_q;
        bits_d = bits_q;
        if (pop_c) begin
            bits_d = {1'b0, bits_q[1]};
            cnt_d  = cnt_q - CNT_W'(1);
        end
        if (Start) begin
            cnt_d  = '0;
            bits_d = '0;
        end else if (accept_c) begin
            if (emit_c.a && emit_c.b) begin
                bits_d = {code_b_c, code_a_c};
                cnt_d  = CNT_W'(2);
            end else begin
                bits_d = {1'b0, (emit_c.a ? code_a_c : code_b_c)};
                cnt_d  = CNT_W'(1);
            end
        end
        valid_d = (cnt_d != CNT_W'(0));
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed and randomized bench for conv_encoder against a generator-polynomial reference model.
module tb_conv_encoder;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic [1:0] Rate;
    logic       InValid;
    logic       InBit;
    logic       InReady;
    logic       OutValid;
    logic       OutBit;
    logic       OutReady;

    int checks = 0;
    int errors = 0;

    logic pend[$];
    logic hist[$];
    logic got[$];
    int   m_rate  = 0;
    int   m_phase = 0;
    logic acc;

    conv_encoder dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Rate     (Rate),
        .InValid  (InValid),
        .InBit    (InBit),
        .InReady  (InReady),
        .OutValid (OutValid),
        .OutBit   (OutBit),
        .OutReady (OutReady)
    );

    initial forever #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int eff_rate(input logic [1:0] r);
`ifdef CONV_PUNCTURE_EN
        return (r == 2'b11) ? 0 : int'(r);
`else
        return (r == 2'b11) ? 0 : 0;
`endif
    endfunction

    // Parity of generator g over (x, s1..s6); polynomial MSB weights the current bit.
    function automatic logic code_bit(input int g, input logic x);
        logic p;
        p = x & logic'((g >> 6) & 1);
        for (int k = 1; k <= 6; k++) begin
            if (((g >> (6 - k)) & 1) == 1 && k <= hist.size()) p = p ^ hist[k-1];
        end
        return p;
    endfunction

    task automatic model_accept(input logic x);
        logic  a;
        logic  b;
        string pat;
        a = code_bit('o133, x);
        b = code_bit('o171, x);
        case (m_rate)
            1:       pat = (m_phase == 0) ? "AB" : "A";
            2:       pat = (m_phase == 0) ? "AB" : ((m_phase == 1) ? "A" : "B");
            default: pat = "AB";
        endcase
        for (int i = 0; i < pat.len(); i++) pend.push_back((pat.getc(i) == 8'h41) ? a : b);
        hist.push_front(x);
        if (hist.size() > 6) hist.delete(6);
        m_phase = (m_phase + 1) % (m_rate + 1);
    endtask

    function automatic void model_clear();
        pend.delete();
        hist.delete();
        m_phase = 0;
    endfunction

    // One clock: drive at negedge, check and update the model, then advance to the next negedge.
    task automatic step(input logic v, input logic b, input logic r, input logic st, output logic accepted);
        logic exp_ready;
        InValid  = v;
        InBit    = b;
        OutReady = r;
        Start    = st;
        #1;
        exp_ready = !st && (pend.size() == 0 || (pend.size() == 1 && r));
        chk("out_valid", OutValid, pend.size() != 0);
        chk("in_ready", InReady, exp_ready);
        if (pend.size() != 0) chk("out_bit", OutBit, pend[0]);
        if (pend.size() != 0 && r) got.push_back(pend.pop_front());
        accepted = 1'b0;
        if (st) begin
            model_clear();
            m_rate = eff_rate(Rate);
        end else if (v && exp_ready) begin
            model_accept(b);
            accepted = 1'b1;
        end
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic feed(input logic b);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 8 && !a; i++) step(1'b1, b, 1'b1, 1'b0, a);
        if (!a) chk("feed_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 10 && pend.size() != 0; i++) step(1'b0, 1'b0, 1'b1, 1'b0, a);
        if (pend.size() != 0) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    // Compare collected output bits with an MSB-first constant of n bits.
    task automatic expect_seq(input string tag, input logic [31:0] bits, input int n);
        chk({tag, "_len"}, got.size() == n, 1'b1);
        for (int i = 0; i < n; i++) chk(tag, (i < got.size()) ? got[i] : 1'bx, bits[n-1-i]);
        got.delete();
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Rate     = 2'b00;
        InValid  = 1'b0;
        InBit    = 1'b0;
        OutReady = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        #1;
        chk("reset_out_valid", OutValid, 1'b0);
        chk("reset_out_bit", OutBit, 1'b0);
        chk("reset_in_ready", InReady, 1'b1);
        @(negedge Clock);
        Reset = 1'b0;
        model_clear();
        m_rate = 0;

        // Impulse at rate 1/2
        Rate = 2'b00;
        step(1'b0, 1'b0, 1'b1, 1'b1, acc);
        got.delete();
        feed(1'b1);
        for (int i = 0; i < 6; i++) feed(1'b0);
        drain();
        expect_seq("impulse_r12", 32'(14'b11_01_11_11_00_10_11), 14);

`ifdef CONV_PUNCTURE_EN
        // Rate 3/4 impulse
        Rate = 2'b10;
        step(1'b0, 1'b0, 1'b1, 1'b1, acc);
        got.delete();
        feed(1'b1);
        for (int i = 0; i < 5; i++) feed(1'b0);
        drain();
        expect_seq("impulse_r34", 32'(8'b1101_1100), 8);

        // Rate 2/3 impulse
        Rate = 2'b01;
        step(1'b0, 1'b0, 1'b1, 1'b1, acc);
        got.delete();
        feed(1'b1);
        for (int i = 0; i < 3; i++) feed(1'b0);
        drain();
        expect_seq("impulse_r23", 32'(6'b110111), 6);

        // Start restarts the puncture phase
        Rate = 2'b10;
        step(1'b0, 1'b0, 1'b1, 1'b1, acc);
        feed(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, acc);
        got.delete();
        feed(1'b1);
        drain();
        expect_seq("phase_restart", 32'(2'b11), 2);
`endif

        // Backpressure holds output and blocks input
        Rate = 2'b00;
        step(1'b0, 1'b0, 1'b1, 1'b1, acc);
        got.delete();
        feed(1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, acc);
            chk("bp_no_accept", acc, 1'b0);
        end
        #1;
        chk("bp_hold_bit", OutBit, 1'b1);
        drain();
        expect_seq("backpressure", 32'(2'b11), 2);

        // Start with a pending bit drops it
        step(1'b0, 1'b0, 1'b1, 1'b1, acc);
        feed(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, acc);
        feed(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, acc);
        chk("mid_pending", pend.size() == 1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, acc);
        got.delete();
        feed(1'b0);
        drain();
        expect_seq("start_mid", 32'(2'b00), 2);

        // Asynchronous reset mid-frame
        Rate = 2'b10;
        step(1'b0, 1'b0, 1'b1, 1'b1, acc);
        feed(1'b1);
        feed(1'b0);
        InValid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset_valid", OutValid, 1'b0);
        model_clear();
        m_rate = 0;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        Rate  = 2'b00;
        got.delete();
        feed(1'b1);
        drain();
        expect_seq("after_reset", 32'(2'b11), 2);

        // Randomized traffic with occasional restarts at random rates
        for (int i = 0; i < 3000; i++) begin
            logic st;
            st   = ($urandom_range(0, 59) == 0);
            Rate = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), st, acc);
        end
        drain();
        got.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
